usb_bit_rx: RTL

Full-speed USB receive front end. Samples the D+/D− line pair at 5× the bit rate, recovers bit timing, and detects SYNC. Performs NRZI decoding and bit unstuffing, then detects EOP. Drives the `packet_rx` bit-stream interface (`rx_start`, `rx_status`, `rx_bit`, `rx_finish`) and sits directly between the transceiver pins and `packet_rx`.

---
 rtl/usb_bit_rx_pkg.sv | 31 +++
 rtl/usb_bit_rx_line_sync.sv | 38 +++
 rtl/usb_bit_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/usb_bit_rx_pkg.sv
// usb_bit_rx_pkg: shared line-state codes, FSM encoding and framing limits
// for the full-speed USB bit receiver.
//   line_t  : decoded {D+, D-} pair (J = 10, K = 01, SE0 = 00, SE1 = 11)
//   state_t : receiver FSM states
package usb_bit_rx_pkg;

    typedef enum logic [1:0] {
        LINE_SE0 = 2'b00,
        LINE_K   = 2'b01,
        LINE_J   = 2'b10,
        LINE_SE1 = 2'b11
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ERR
    } state_t;

    // Consecutive ones after which a stuffed zero is expected.
    localparam int STUFF_LIMIT = 6;
    // Minimum number of SYNC zeros before the closing one is accepted.
    localparam int SYNC_MIN_ZEROS = 3;

    function automatic logic is_jk(input line_t l);
        return (l == LINE_J) || (l == LINE_K);
    endfunction

endpackage

// File: rtl/usb_bit_rx_line_sync.sv
// usb_line_sync: two-flop synchronizer on D+/D- plus line-state decode.
//   clk, rst   : clock, asynchronous active-high reset
//   dp, dm     : raw pins, asynchronous to clk
//   line       : synchronized line state (two cycles behind the pins)
//   transition : high for the one cycle in which line moves J->K or K->J
module usb_line_sync
    import usb_bit_rx_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  dp,
    input  logic  dm,
    output line_t line,
    output logic  transition
);

    line_t meta;
    line_t sync;
    line_t last;

    // All stages reset to J so that leaving reset on an idle bus shows no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= LINE_J;
            sync <= LINE_J;
            last <= LINE_J;
        end else begin
            meta <= line_t'({dp, dm});
            sync <= meta;
            last <= sync;
        end
    end

    assign line = sync;
    // Only differential edges carry timing; SE0/SE1 edges are ignored.
    assign transition = is_jk(sync) && is_jk(last) && (sync != last);

endmodule

// File: rtl/usb_bit_rx.sv
// usb_bit_rx: full-speed USB receive front end (bit recovery, SYNC detect,
// NRZI decode, bit unstuffing, EOP detect) feeding a packet_rx bit stream.
//   clk, rst  : 60 MHz clock, asynchronous active-high reset
//   dp, dm    : raw D+/D- pins
//   rx_start  : one-cycle pulse when SYNC completes
//   rx_status : one-cycle strobe per decoded, unstuffed bit
//   rx_bit    : decoded bit, valid with rx_status
//   rx_finish : one-cycle pulse on a valid EOP
//   rx_error  : one-cycle pulse on stuff error, SE1 or bad EOP
//   rx_active : high from rx_start through rx_finish/rx_error
// Build option: define USB_RX_STUFF_ERR_EN to flag a one in a stuff-bit slot
// as an error; otherwise that slot is always discarded.
module usb_bit_rx
    import usb_bit_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5,
    parameter int SAMPLE_PT    = 2,
    parameter int IDLE_BITS    = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic dp,
    input  logic dm,
    output logic rx_start,
    output logic rx_status,
    output logic rx_bit,
    output logic rx_finish,
    output logic rx_error,
    output logic rx_active
);

    localparam int PW = $clog2(CLKS_PER_BIT + 1);
    localparam int JW = $clog2(IDLE_BITS + 1);

    line_t   line;
    logic    transition;
    logic    sample;
    logic    dbit;
    logic [PW-1:0] phase;

    state_t  state, state_n;
    line_t   prev, prev_n;
    logic [2:0]    zc, zc_n;
    logic [2:0]    ones, ones_n;
    logic [1:0]    se0n, se0_n;
    logic [JW-1:0] jn, jn_n;
    logic    start_n, status_n, bit_n, finish_n, error_n, active_n;

    usb_line_sync u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .dp        (dp),
        .dm        (dm),
        .line      (line),
        .transition(transition)
    );

    // Phase counter re-aligns on every differential edge and free-runs
    // across runs of identical bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            phase <= '0;
        else if (transition || phase == PW'(CLKS_PER_BIT - 1))
            phase <= '0;
        else
            phase <= phase + PW'(1);
    end

    // An edge landing on the sample slot starts a new bit; sampling it here
    // as well would read that bit twice.
    assign sample = !transition && (phase == PW'(SAMPLE_PT));
    assign dbit   = (line == prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            prev      <= LINE_J;
            zc        <= '0;
            ones      <= '0;
            se0n      <= '0;
            jn        <= '0;
            rx_start  <= 1'b0;
            rx_status <= 1'b0;
            rx_bit    <= 1'b0;
            rx_finish <= 1'b0;
            rx_error  <= 1'b0;
            rx_active <= 1'b0;
        end else begin
            state     <= state_n;
            prev      <= prev_n;
            zc        <= zc_n;
            ones      <= ones_n;
            se0n      <= se0_n;
            jn        <= jn_n;
            rx_start  <= start_n;
            rx_status <= status_n;
            rx_bit    <= bit_n;
            rx_finish <= finish_n;
            rx_error  <= error_n;
            rx_active <= active_n;
        end
    end

    always_comb begin
        state_n  = state;
        prev_n   = prev;
        zc_n     = zc;
        ones_n   = ones;
        se0_n    = se0n;
        jn_n     = jn;
        start_n  = 1'b0;
        status_n = 1'b0;
        bit_n    = rx_bit;
        finish_n = 1'b0;
        error_n  = 1'b0;
        if (sample) begin
            prev_n = is_jk(line) ? line : prev;
            case (state)
                ST_IDLE: begin
                    if (line == LINE_K) begin
                        state_n = ST_SYNC;
                        zc_n    = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (!is_jk(line))
                        state_n = ST_IDLE;
                    else if (!dbit)
                        zc_n = (zc == 3'd7) ? zc : zc + 3'd1;
                    else if (zc >= 3'(SYNC_MIN_ZEROS)) begin
                        state_n = ST_DATA;
                        start_n = 1'b1;
                        ones_n  = 3'd1;
                    end else
                        state_n = ST_IDLE;
                end
                ST_DATA: begin
                    if (line == LINE_SE0) begin
                        state_n = ST_EOP;
                        se0_n   = 2'd1;
                    end else if (line == LINE_SE1) begin
                        state_n = ST_ERR;
                        error_n = 1'b1;
                        jn_n    = '0;
                    end else if (ones == 3'(STUFF_LIMIT)) begin
`ifdef USB_RX_STUFF_ERR_EN
                        if (dbit) begin
                            state_n = ST_ERR;
                            error_n = 1'b1;
                            jn_n    = '0;
                        end else
                            ones_n = '0;
`else
                        ones_n = '0;
`endif
                    end else begin
                        status_n = 1'b1;
                        bit_n    = dbit;
                        ones_n   = dbit ? ones + 3'd1 : 3'd0;
                    end
                end
                ST_EOP: begin
                    if (line == LINE_SE0 && se0n != 2'd3)
                        se0_n = se0n + 2'd1;
                    else if (line == LINE_J) begin
                        state_n  = ST_IDLE;
                        finish_n = 1'b1;
                    end else begin
                        state_n = ST_ERR;
                        error_n = 1'b1;
                        jn_n    = '0;
                    end
                end
                ST_ERR: begin
                    if (line != LINE_J)
                        jn_n = '0;
                    else if (jn == JW'(IDLE_BITS - 1)) begin
                        state_n = ST_IDLE;
                        jn_n    = '0;
                    end else
                        jn_n = jn + JW'(1);
                end
                default: state_n = ST_IDLE;
            endcase
        end
        // Errors only arise inside a packet, so the terminating pulse is the
        // last cycle of rx_active.
        active_n = (state_n == ST_DATA) || (state_n == ST_EOP) || finish_n || error_n;
    end

endmodule
